fpu_issue: RTL and testbench

FPU_ISSUE -- requirements
Module: fpu_issue

---
 rtl/fpu_issue_if.sv | 23 ++
 rtl/fpu_issue.sv | 146 ++++++++++++++
 tb/tb_fpu_issue.sv | 276 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/fpu_issue_if.sv
// Request/response handshake bundle for the FPU issue stage.
// master drives requests and accepts responses; slave is the issue block.
interface fpu_issue_if;
    logic        req_valid;
    logic        req_ready;
    logic [5:0]  req_op;
    logic [31:0] req_rs1;
    logic [31:0] req_rs2;
    logic [2:0]  req_rm;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [31:0] rsp_result;

    modport master (
        output req_valid, req_op, req_rs1, req_rs2, req_rm, rsp_ready,
        input  req_ready, rsp_valid, rsp_result
    );

    modport slave (
        input  req_valid, req_op, req_rs1, req_rs2, req_rm, rsp_ready,
        output req_ready, rsp_valid, rsp_result
    );
endinterface

// File: rtl/fpu_issue.sv
// FPU issue stage: holds one op for the datapath latency and owns fcsr.
// Optional FPU_ISSUE_BYPASS_EN lets DONE accept the next request directly.
module fpu_issue (
    input  logic        clk,
    input  logic        resetn,
    fpu_issue_if.slave  io,
    output logic [5:0]  fpu_operation,
    output logic [31:0] fpu_rs1,
    output logic [31:0] fpu_rs2,
    output logic [31:0] fpu_fcsr,
    input  logic [31:0] fpu_result,
    input  logic [4:0]  fpu_flags,
    input  logic        csr_we,
    input  logic [31:0] csr_wdata,
    output logic [31:0] fcsr
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t      state;
    logic [3:0]  cnt;
    logic [7:0]  fcsr_q;
    logic [7:0]  fpu_fcsr_q;
    logic [31:0] rsp_result_q;
    logic        rsp_valid_q;
    logic        req_ready_q;
    logic        illegal_q;

    logic [2:0]  eff_rm;
    logic        req_illegal;
    logic        req_legal;
    logic [3:0]  lat_m1;
    logic [4:0]  flags_in;
    logic        accept;
    logic        capture;
    logic        unused_wdata;

    assign unused_wdata = ^csr_wdata[31:8];

    always_comb begin
        eff_rm = io.req_rm;
        if (io.req_rm == 3'b111) eff_rm = fcsr_q[7:5];
        req_illegal = (io.req_op > 6'd16) ||
                      (eff_rm == 3'd5) || (eff_rm == 3'd6);
        req_legal = !req_illegal;
        lat_m1 = 4'd0;
        unique case (1'b1)
            req_legal && (io.req_op == 6'd0): lat_m1 = 4'd1;
            req_legal && (io.req_op == 6'd1): lat_m1 = 4'd2;
            req_legal && (io.req_op == 6'd2 ||
                          io.req_op == 6'd3): lat_m1 = 4'd11;
            default: lat_m1 = 4'd0;
        endcase
    end

    // illegal ops report NV only; datapath flags are meaningless then
    assign flags_in = illegal_q ? 5'b10000 : fpu_flags;
    assign accept   = io.req_valid && io.req_ready;
    assign capture  = (state == BUSY) && (cnt == 4'd0);

`ifdef FPU_ISSUE_BYPASS_EN
    assign io.req_ready = req_ready_q ||
                          ((state == DONE) && io.rsp_ready);
`else
    assign io.req_ready = req_ready_q;
`endif

    assign io.rsp_valid  = rsp_valid_q;
    assign io.rsp_result = rsp_result_q;
    assign fpu_fcsr      = {24'b0, fpu_fcsr_q};
    assign fcsr          = {24'b0, fcsr_q};

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state         <= IDLE;
            cnt           <= 4'd0;
            fcsr_q        <= 8'd0;
            fpu_fcsr_q    <= 8'd0;
            rsp_result_q  <= 32'd0;
            rsp_valid_q   <= 1'b0;
            req_ready_q   <= 1'b1;
            illegal_q     <= 1'b0;
            fpu_operation <= 6'd0;
            fpu_rs1       <= 32'd0;
            fpu_rs2       <= 32'd0;
        end else begin
            if (csr_we) fcsr_q <= csr_wdata[7:0];
            if (capture) begin
                fcsr_q[4:0] <= (csr_we ? csr_wdata[4:0] : fcsr_q[4:0])
                               | flags_in;
                rsp_result_q <= illegal_q ? 32'd0 : fpu_result;
            end
            // rm and flags are frozen here so later csr writes miss this op
            if (accept) begin
                fpu_operation <= io.req_op;
                fpu_rs1       <= io.req_rs1;
                fpu_rs2       <= io.req_rs2;
                fpu_fcsr_q    <= {eff_rm, fcsr_q[4:0]};
                illegal_q     <= req_illegal;
                cnt           <= lat_m1;
            end
            unique case (state)
                IDLE: begin
                    if (accept) begin
                        state       <= BUSY;
                        req_ready_q <= 1'b0;
                    end
                end
                BUSY: begin
                    if (cnt == 4'd0) begin
                        state       <= DONE;
                        rsp_valid_q <= 1'b1;
                    end else begin
                        cnt <= cnt - 4'd1;
                    end
                end
                DONE: begin
                    if (io.rsp_ready) begin
                        rsp_valid_q <= 1'b0;
`ifdef FPU_ISSUE_BYPASS_EN
                        if (io.req_valid) begin
                            state <= BUSY;
                        end else begin
                            state       <= IDLE;
                            req_ready_q <= 1'b1;
                        end
`else
                        state       <= IDLE;
                        req_ready_q <= 1'b1;
`endif
                    end
                end
                default: begin
                    state       <= IDLE;
                    req_ready_q <= 1'b1;
                    rsp_valid_q <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_fpu_issue.sv
// Directed bench for fpu_issue: latency, operand hold, fcsr/rm handling,
// illegal ops, back-to-back throughput and reset abort.
module tb_fpu_issue;

    logic        clk;
    logic        resetn;
    logic [5:0]  fpu_operation;
    logic [31:0] fpu_rs1;
    logic [31:0] fpu_rs2;
    logic [31:0] fpu_fcsr;
    logic [31:0] fpu_result;
    logic [4:0]  fpu_flags;
    logic        csr_we;
    logic [31:0] csr_wdata;
    logic [31:0] fcsr;

    int n_chk;
    int n_fail;

    fpu_issue_if bus ();

    fpu_issue dut (
        .clk           (clk),
        .resetn        (resetn),
        .io            (bus),
        .fpu_operation (fpu_operation),
        .fpu_rs1       (fpu_rs1),
        .fpu_rs2       (fpu_rs2),
        .fpu_fcsr      (fpu_fcsr),
        .fpu_result    (fpu_result),
        .fpu_flags     (fpu_flags),
        .csr_we        (csr_we),
        .csr_wdata     (csr_wdata),
        .fcsr          (fcsr)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
    endtask

    task automatic csr_write(input logic [31:0] d);
        @(negedge clk);
        csr_we    = 1'b1;
        csr_wdata = d;
        @(posedge clk);
        #1 csr_we = 1'b0;
    endtask

    // returns at the accepting posedge
    task automatic send(input logic [5:0] op, input logic [31:0] a,
                        input logic [31:0] b, input logic [2:0] rm);
        @(negedge clk);
        bus.req_valid = 1'b1;
        bus.req_op    = op;
        bus.req_rs1   = a;
        bus.req_rs2   = b;
        bus.req_rm    = rm;
        for (int i = 0; i < 40; i++) begin
            if (bus.req_ready) break;
            @(negedge clk);
        end
        chk("send_ready", {31'd0, bus.req_ready}, 32'd1);
        @(posedge clk);
    endtask

    // lat = edges from accept to the response transfer edge
    task automatic wait_rsp(output int lat, output int unstable,
                            output logic [31:0] res);
        logic [5:0]  op0;
        logic [31:0] a0, b0, f0;
        lat = -1;
        unstable = 0;
        res = 32'hxxxxxxxx;
        op0 = '0; a0 = '0; b0 = '0; f0 = '0;
        for (int k = 1; k <= 40; k++) begin
            @(negedge clk);
            bus.req_valid = 1'b0;
            if (k == 1) begin
                op0 = fpu_operation; a0 = fpu_rs1;
                b0 = fpu_rs2; f0 = fpu_fcsr;
            end else if (!bus.rsp_valid &&
                         {op0, a0, b0, f0} !==
                         {fpu_operation, fpu_rs1, fpu_rs2, fpu_fcsr}) begin
                unstable++;
            end
            if (bus.rsp_valid) begin
                lat = k;
                res = bus.rsp_result;
                break;
            end
        end
        @(posedge clk);
    endtask

    int          lat;
    int          unst;
    logic [31:0] res;
    int          acc_n;
    int          acc_c0;
    int          acc_c1;
    int          overlap;
    int          seen;

    initial begin
        n_chk = 0;
        n_fail = 0;
        resetn = 1'b0;
        bus.req_valid = 1'b0;
        bus.req_op    = '0;
        bus.req_rs1   = '0;
        bus.req_rs2   = '0;
        bus.req_rm    = '0;
        bus.rsp_ready = 1'b1;
        fpu_result = '0;
        fpu_flags  = '0;
        csr_we     = 1'b0;
        csr_wdata  = '0;

        // reset state
        #12;
        chk("rst_req_ready", {31'd0, bus.req_ready}, 32'd1);
        chk("rst_rsp_valid", {31'd0, bus.rsp_valid}, 32'd0);
        chk("rst_fcsr", fcsr, 32'd0);
        chk("rst_rsp_result", bus.rsp_result, 32'd0);
        chk("rst_fpu_op", {26'd0, fpu_operation}, 32'd0);
        chk("rst_fpu_rs1", fpu_rs1, 32'd0);
        @(negedge clk);
        resetn = 1'b1;
        @(posedge clk);
        #1 chk("rel_req_ready", {31'd0, bus.req_ready}, 32'd1);

        // single-cycle op: LAT 1 -> transfer 2 edges after accept
        fpu_result = 32'h40400000;
        send(6'd4, 32'd3, 32'd0, 3'd0);
        #1;
        chk("op4_fpu_op", {26'd0, fpu_operation}, 32'd4);
        chk("op4_fpu_rs1", fpu_rs1, 32'd3);
        wait_rsp(lat, unst, res);
        chk("op4_lat", lat, 32'd2);
        chk("op4_result", res, 32'h40400000);
        chk("op4_fcsr", fcsr, 32'd0);

        // divide: 12 busy cycles, operands held throughout
        fpu_result = 32'h3f000000;
        send(6'd2, 32'h11111111, 32'h22222222, 3'd1);
        wait_rsp(lat, unst, res);
        chk("div_lat", lat, 32'd13);
        chk("div_stable", unst, 32'd0);
        chk("div_result", res, 32'h3f000000);

        // dynamic rm from fcsr, flag accumulation
        csr_write(32'h20);
        chk("csr_wr", fcsr, 32'h20);
        fpu_flags = 5'b00001;
        fpu_result = 32'h0;
        send(6'd0, 32'd1, 32'd2, 3'd7);
        #1 chk("dyn_fpu_fcsr", fpu_fcsr, 32'h20);
        wait_rsp(lat, unst, res);
        chk("add_lat", lat, 32'd3);
        chk("add_fcsr", fcsr, 32'h21);

        // rm sampled at accept; csr write mid-flight does not reach FPU
        fpu_flags = 5'b0;
        csr_write(32'h40);
        send(6'd1, 32'd5, 32'd6, 3'd7);
        @(negedge clk);
        bus.req_valid = 1'b0;
        csr_we = 1'b1;
        csr_wdata = 32'h80;
        @(posedge clk);
        @(negedge clk);
        csr_we = 1'b0;
        chk("mid_fcsr", fcsr, 32'h80);
        chk("mid_fpu_fcsr", fpu_fcsr, 32'h40);
        wait_rsp(lat, unst, res);
        chk("mul_lat_rem", lat, 32'd2);
        chk("mul_stable", unst, 32'd0);

        // illegal op code
        csr_write(32'h0);
        fpu_flags = 5'b00001;
        fpu_result = 32'hdeadbeef;
        send(6'd20, 32'd1, 32'd1, 3'd0);
        wait_rsp(lat, unst, res);
        chk("ill_op_lat", lat, 32'd2);
        chk("ill_op_result", res, 32'd0);
        chk("ill_op_fcsr", fcsr, 32'h10);

        // illegal static rm on a normally 2-cycle op
        csr_write(32'h0);
        send(6'd0, 32'd1, 32'd1, 3'd5);
        wait_rsp(lat, unst, res);
        chk("ill_rm_lat", lat, 32'd2);
        chk("ill_rm_result", res, 32'd0);
        chk("ill_rm_fcsr", fcsr, 32'h10);

        // csr write coinciding with flag capture
        fpu_flags = 5'b00100;
        fpu_result = 32'h00001234;
        send(6'd4, 32'd7, 32'd8, 3'd0);
        @(negedge clk);
        bus.req_valid = 1'b0;
        csr_we = 1'b1;
        csr_wdata = 32'h0;
        @(posedge clk);
        @(negedge clk);
        csr_we = 1'b0;
        chk("coin_rsp_valid", {31'd0, bus.rsp_valid}, 32'd1);
        chk("coin_fcsr", fcsr, 32'h04);
        chk("coin_result", bus.rsp_result, 32'h00001234);
        @(posedge clk);

        // back-to-back op 8 with rsp_ready held
        fpu_flags = 5'b0;
        acc_n = 0; acc_c0 = -1; acc_c1 = -1; overlap = 0;
        @(negedge clk);
        bus.req_valid = 1'b1;
        bus.req_op = 6'd8;
        bus.req_rm = 3'd0;
        for (int c = 0; c < 12; c++) begin
            if (bus.req_ready) begin
                if (acc_n == 0) acc_c0 = c;
                if (acc_n == 1) acc_c1 = c;
                acc_n++;
            end
            if (bus.req_ready && bus.rsp_valid) overlap++;
            @(negedge clk);
        end
        bus.req_valid = 1'b0;
`ifdef FPU_ISSUE_BYPASS_EN
        chk("b2b_count", acc_n, 32'd6);
        chk("b2b_gap", acc_c1 - acc_c0, 32'd2);
`else
        chk("b2b_count", acc_n, 32'd4);
        chk("b2b_gap", acc_c1 - acc_c0, 32'd3);
        chk("b2b_overlap", overlap, 32'd0);
`endif
        repeat (5) @(negedge clk);

        // reset while busy aborts without response or flags
        csr_write(32'h1f);
        fpu_flags = 5'b00001;
        send(6'd2, 32'd9, 32'd9, 3'd0);
        @(negedge clk);
        bus.req_valid = 1'b0;
        repeat (2) @(negedge clk);
        resetn = 1'b0;
        #1;
        chk("abort_fcsr", fcsr, 32'd0);
        chk("abort_fpu_op", {26'd0, fpu_operation}, 32'd0);
        @(negedge clk);
        resetn = 1'b1;
        @(posedge clk);
        #1 chk("abort_req_ready", {31'd0, bus.req_ready}, 32'd1);
        seen = 0;
        for (int c = 0; c < 15; c++) begin
            @(negedge clk);
            if (bus.rsp_valid) seen++;
        end
        chk("abort_no_rsp", seen, 32'd0);
        chk("abort_fcsr_after", fcsr, 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule
